note_tone_generator: RTL



---
 rtl/tone_pkg.sv | 16 +
 rtl/pitch_lut.sv | 15 +
 rtl/note_tone_generator.sv | 80 ++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: shared FSM states, note codes and octave-4 pitch table for the buzzer tone path
package tone_pkg;
  localparam int HP_W = 24;
  localparam logic [3:0] MAX_OCTAVE = 4'd8;
  typedef enum logic [1:0] {IDLE, GAP, PLAY} state_e;
  typedef enum logic [3:0] {REST, C, CS, D, DS, E, F, FS, G, GS, A, AS, B} note_e;
  localparam logic [HP_W-1:0] BASE_HP_OCT4 [12] = '{
    24'd191113, 24'd180386, 24'd170262, 24'd160706, 24'd151686, 24'd143173,
    24'd135139, 24'd127551, 24'd120395, 24'd113636, 24'd107259, 24'd101239
  };
  function automatic logic [HP_W-1:0] hp_of(input logic [3:0] note, input logic [3:0] octave);
    logic [HP_W-1:0] base;
    base = (note >= C && note <= B) ? BASE_HP_OCT4[note - 4'd1] : '0;
    return (octave > MAX_OCTAVE) ? '0 : (octave >= 4'd4) ? base >> (octave - 4'd4) : base << (4'd4 - octave);
  endfunction
endpackage

// File: rtl/pitch_lut.sv
// pitch_lut: registered note/octave to half-period lookup, zero for rests and invalid codes
module pitch_lut
  import tone_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      note,
  input  logic [3:0]      octave,
  output logic [HP_W-1:0] hp
);
  // register the shifted table entry so the shifter stays off the FSM path
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hp <= '0;
    else hp <= hp_of(note, octave);
endmodule

// File: rtl/note_tone_generator.sv
// note_tone_generator: square-wave buzzer driver with articulation gaps between score notes
module note_tone_generator
  import tone_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 1000000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [7:0]      note_pointer,
  input  logic [3:0]      cur_note,
  input  logic [3:0]      cur_octave,
  output logic            buzzer,
  output logic            tone_active,
  output logic [HP_W-1:0] half_period
);
  logic [16:0]     sync_q [SYNC_STAGES];
  logic [15:0]     tup_s, tup_p, acc;
  logic            en_s, accept, ptr_chg;
  logic [HP_W-1:0] lut_hp, tgt_hp, cur_tgt, cnt;
  logic [31:0]     gcnt;
  state_e          state;
  assign {en_s, tup_s} = sync_q[SYNC_STAGES-1];
  assign accept        = tup_s == tup_p && tup_s != acc;
  assign ptr_chg       = accept && tup_s[15:8] != acc[15:8];
  assign cur_tgt       = accept ? lut_hp : tgt_hp;
  assign tone_active   = state == PLAY;
  pitch_lut u_lut (
    .clk    (clk),
    .rst_n  (rst_n),
    .note   (tup_s[7:4]),
    .octave (tup_s[3:0]),
    .hp     (lut_hp)
  );
  // synchronise inputs and track the accepted tuple; this keeps running while disabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      tup_p  <= '0;
      acc    <= '0;
      tgt_hp <= '0;
    end else begin
      sync_q[0] <= {en, note_pointer, cur_note, cur_octave};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      tup_p  <= tup_s;
      if (accept) acc <= tup_s;
      tgt_hp <= cur_tgt;
    end
  // tone FSM: pointer changes open a gap, pitch changes land only on toggle boundaries
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      buzzer      <= 1'b0;
      half_period <= '0;
      cnt         <= '0;
      gcnt        <= '0;
    end else if (!en_s || (ptr_chg && GAP_CYCLES != 0)) begin
      state       <= en_s ? GAP : IDLE;
      buzzer      <= 1'b0;
      half_period <= '0;
      cnt         <= '0;
      gcnt        <= '0;
    end else if (ptr_chg || state == IDLE || (state == GAP && gcnt == GAP_CYCLES - 1)) begin
      state       <= cur_tgt != '0 ? PLAY : IDLE;
      buzzer      <= cur_tgt != '0;
      half_period <= cur_tgt;
      cnt         <= '0;
      gcnt        <= '0;
    end else if (state == GAP) begin
      gcnt <= gcnt + 32'd1;
    end else if (cnt == half_period - HP_W'(1)) begin
      state       <= cur_tgt != '0 ? PLAY : IDLE;
      buzzer      <= cur_tgt != '0 && !buzzer;
      half_period <= cur_tgt;
      cnt         <= '0;
    end else begin
      cnt <= cnt + HP_W'(1);
    end
endmodule
